// File: rtl/calc_disp_pkg.sv
// Shared definitions for the calculator display path.
// Holds the segment-decoder digit codes, the operator-select encoding,
// the magnitude width fed to the BCD engine and the default scan period.
package calc_disp_pkg;

    // Digit codes understood by the downstream segment decoder.
    localparam logic [3:0] CODE_ADD   = 4'd10;
    localparam logic [3:0] CODE_MUL   = 4'd11;
    localparam logic [3:0] CODE_SUB   = 4'd12;
    localparam logic [3:0] CODE_BLANK = 4'd14;
    localparam logic [3:0] CODE_NEG   = 4'd15;

    // op_sel encoding.
    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_MUL  = 2'd2,
        OP_NONE = 2'd3
    } op_sel_e;

    localparam int unsigned DIGIT_PERIOD_DEFAULT = 25000;
    localparam int unsigned BIN_WIDTH            = 14;

    function automatic logic [3:0] op_code(input op_sel_e op);
        case (op)
            OP_ADD:  return CODE_ADD;
            OP_SUB:  return CODE_SUB;
            OP_MUL:  return CODE_MUL;
            default: return CODE_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: 14-bit binary to four BCD digits,
// one shift per clock. A start pulse (re)loads the engine, aborting any
// conversion in flight. done is a one-cycle pulse on the cycle after the
// final shift, while bcd holds the result.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load bin and begin converting
//   bin        : binary magnitude
//   bcd        : digits 3..0 packed as nibbles, digit 0 in bcd[3:0]
//   done       : result valid pulse
module bin2bcd_seq
    import calc_disp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin,
    output logic [15:0]          bcd,
    output logic                 done
);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e               state;
    logic [BIN_WIDTH-1:0] shift_bin;
    logic [15:0]          bcd_r;
    logic [3:0]           iter_left;
    logic [15:0]          bcd_adj;

    // Add-3 correction on every nibble that would reach 10 after the shift.
    always_comb begin
        bcd_adj = bcd_r;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_r[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_r[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            shift_bin <= '0;
            bcd_r     <= '0;
            iter_left <= '0;
            done      <= 1'b0;
        end else if (start) begin
            state     <= S_RUN;
            shift_bin <= bin;
            bcd_r     <= '0;
            iter_left <= 4'(BIN_WIDTH);
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_RUN) begin
                {bcd_r, shift_bin} <= {bcd_adj, shift_bin} << 1;
                iter_left          <= iter_left - 4'd1;
                if (iter_left == 4'd1) begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign bcd = bcd_r;

endmodule

// File: rtl/calc_display_scan.sv
// Seven-segment display front end for the keyboard calculator.
// Captures a signed value (and optional operator) on load, converts the
// magnitude to BCD, formats it (range check, leading-zero blanking, sign,
// operator) into four display registers, and scans those registers onto a
// single code bus with active-low anode enables.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : one-cycle strobe sampling value/show_op/op_sel
//   value      : signed two's-complement number
//   show_op    : digit 3 shows the operator, digits 2..0 the value
//   op_sel     : operator select (add/sub/mul/blank)
//   ssd_in     : code of the currently lit digit
//   ssd_an     : active-low anode enables, bit 0 = rightmost digit
//   busy       : conversion in progress
module calc_display_scan
    import calc_disp_pkg::*;
#(
    parameter int unsigned DIGIT_PERIOD = DIGIT_PERIOD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [14:0] value,
    input  logic        show_op,
    input  logic [1:0]  op_sel,
    output logic [3:0]  ssd_in,
    output logic [3:0]  ssd_an,
    output logic        busy
);

    localparam int unsigned CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;

    // ---------------- capture ----------------
    logic signed [14:0]   value_s;
    logic [BIN_WIDTH-1:0] mag;
    logic                 in_range;

    always_comb begin
        value_s = value;
        // -16384 wraps to 0 here, but it is always out of range.
        mag = value[14] ? (~value[13:0] + 14'd1) : value[13:0];
        if (show_op) begin
            in_range = (value_s >= -15'sd99) && (value_s <= 15'sd999);
        end else begin
            in_range = (value_s >= -15'sd999) && (value_s <= 15'sd9999);
        end
    end

    logic    neg_r;
    logic    show_op_r;
    op_sel_e op_r;
    logic    oor_r;

    // ---------------- conversion ----------------
    logic [15:0] bcd;
    logic        bcd_done;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (load),
        .bin   (mag),
        .bcd   (bcd),
        .done  (bcd_done)
    );

    // ---------------- formatting ----------------
    logic [3:0] bcd_dig [4];
    logic [3:0] fmt     [4];
    logic [1:0] msd;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            bcd_dig[i] = bcd[i*4 +: 4];
        end
        // Most significant nonzero digit; zero shows as a single "0".
        msd = 2'd0;
        for (int unsigned i = 1; i < 4; i++) begin
            if (bcd_dig[i] != 4'd0) begin
                msd = 2'(i);
            end
        end
        // The range check guarantees the sign position stays inside the field.
        for (int unsigned i = 0; i < 4; i++) begin
            if (oor_r) begin
                fmt[i] = CODE_NEG;
            end else if (2'(i) <= msd) begin
                fmt[i] = bcd_dig[i];
            end else if (neg_r && (2'(i) == msd + 2'd1)) begin
                fmt[i] = CODE_NEG;
            end else begin
                fmt[i] = CODE_BLANK;
            end
        end
        if (show_op_r) begin
            fmt[3] = op_code(op_r);
        end
    end

    // ---------------- control / display registers ----------------
    logic [3:0] disp [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            neg_r     <= 1'b0;
            show_op_r <= 1'b0;
            op_r      <= OP_ADD;
            oor_r     <= 1'b0;
            disp[3]   <= CODE_BLANK;
            disp[2]   <= CODE_BLANK;
            disp[1]   <= CODE_BLANK;
            disp[0]   <= 4'd0;
        end else if (load) begin
            neg_r     <= value[14];
            show_op_r <= show_op;
            op_r      <= op_sel_e'(op_sel);
            oor_r     <= ~in_range;
            busy      <= 1'b1;
        end else if (busy && bcd_done) begin
            disp <= fmt;
            busy <= 1'b0;
        end
    end

    // ---------------- scan ----------------
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       digit_idx;
    logic [1:0]       next_idx;
    logic             wrap;

    always_comb begin
        wrap     = (scan_cnt == CNT_W'(DIGIT_PERIOD - 1));
        next_idx = wrap ? digit_idx + 2'd1 : digit_idx;
    end

    // Anode and code are both registered from next_idx so they switch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
            ssd_an    <= 4'b1110;
            ssd_in    <= 4'd0;
        end else begin
            scan_cnt  <= wrap ? '0 : scan_cnt + CNT_W'(1);
            digit_idx <= next_idx;
            ssd_an    <= ~(4'b0001 << next_idx);
            ssd_in    <= disp[next_idx];
        end
    end

endmodule

// File: tb/tb_calc_display_scan.sv
// Directed bench for calc_display_scan with DIGIT_PERIOD=4. Expected
// display contents (digits 3..0 as hex nibbles) are queued when a load is
// driven and popped when a full scan has been collected from the outputs.
module tb_calc_display_scan;

    localparam int unsigned DP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [14:0] value = '0;
    logic        show_op = 1'b0;
    logic [1:0]  op_sel = '0;
    logic [3:0]  ssd_in;
    logic [3:0]  ssd_an;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q [$];
    logic [15:0] cur_disp = 16'hEEE0;

    always #5 clk = ~clk;

    calc_display_scan #(.DIGIT_PERIOD(DP)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .value   (value),
        .show_op (show_op),
        .op_sel  (op_sel),
        .ssd_in  (ssd_in),
        .ssd_an  (ssd_an),
        .busy    (busy)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int an_to_idx(input logic [3:0] an);
        case (an)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Lit digit matches the display contents the bench believes are current.
    function automatic bit hold_match();
        int idx;
        idx = an_to_idx(ssd_an);
        if (idx < 0) return 1'b0;
        return ssd_in === cur_disp[idx*4 +: 4];
    endfunction

    task automatic start_load(input logic [14:0] v, input logic so, input logic [1:0] os);
        value   = v;
        show_op = so;
        op_sel  = os;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    // Called right after the load edge; counts cycles with busy observed high.
    task automatic wait_busy(input string tag);
        int n;
        bit hold_ok;
        n = 0;
        hold_ok = 1'b1;
        while (busy === 1'b1 && n < 100) begin
            if (!hold_match()) hold_ok = 1'b0;
            n++;
            tick();
        end
        if (!hold_match()) hold_ok = 1'b0;
        check({tag, " busy_cycles"}, 16'(n), 16'd15);
        check({tag, " display_held"}, {15'd0, hold_ok}, 16'd1);
    endtask

    task automatic scan_check(input string tag);
        logic [15:0] got;
        logic [15:0] exp;
        logic [3:0]  seen;
        bit          an_ok;
        int          idx;
        got   = '0;
        seen  = '0;
        an_ok = 1'b1;
        tick();
        for (int c = 0; c < int'(4 * DP); c++) begin
            idx = an_to_idx(ssd_an);
            if (idx < 0) begin
                an_ok = 1'b0;
            end else begin
                got[idx*4 +: 4] = ssd_in;
                seen[idx] = 1'b1;
            end
            tick();
        end
        check({tag, " anode_scan"}, {15'd0, (an_ok && seen == 4'hF)}, 16'd1);
        if (exp_q.size() == 0) begin
            check({tag, " queue_nonempty"}, 16'(exp_q.size()), 16'd1);
        end else begin
            exp = exp_q.pop_front();
            check({tag, " digits"}, got, exp);
            cur_disp = exp;
        end
    endtask

    task automatic do_conv(input string tag, input logic [14:0] v, input logic so,
                           input logic [1:0] os, input logic [15:0] exp);
        exp_q.push_back(exp);
        start_load(v, so, os);
        wait_busy(tag);
        scan_check(tag);
    endtask

    initial begin
        bit pre_ok;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst ssd_an", {12'd0, ssd_an}, 16'h000E);
        check("rst ssd_in", {12'd0, ssd_in}, 16'h0000);
        check("rst busy", {15'd0, busy}, 16'h0000);
        rst_n = 1'b1;
        tick();
        exp_q.push_back(16'hEEE0);
        scan_check("reset_scan");

        // Plain conversions, 4-digit field
        do_conv("v1234",  15'(1234),   1'b0, 2'd0, 16'h1234);
        do_conv("vm5",    15'(-5),     1'b0, 2'd0, 16'hEEF5);
        do_conv("vm999",  15'(-999),   1'b0, 2'd0, 16'hF999);
        do_conv("v0",     15'(0),      1'b0, 2'd0, 16'hEEE0);
        do_conv("v10000", 15'(10000),  1'b0, 2'd0, 16'hFFFF);
        do_conv("vm1000", 15'(-1000),  1'b0, 2'd0, 16'hFFFF);
        do_conv("v9999",  15'(9999),   1'b0, 2'd0, 16'h9999);

        // Operator mode, 3-digit field
        do_conv("op_mul_m42",  15'(-42),  1'b1, 2'd2, 16'hBF42);
        do_conv("op_add_1000", 15'(1000), 1'b1, 2'd0, 16'hAFFF);
        do_conv("op_sub_m99",  15'(-99),  1'b1, 2'd1, 16'hCF99);
        do_conv("op_none_5",   15'(5),    1'b1, 2'd3, 16'hEEE5);

        // Restart: second load on the 5th busy cycle; only the final value shows
        exp_q.push_back(16'hEEE7);
        start_load(15'(1234), 1'b0, 2'd0);
        pre_ok = 1'b1;
        repeat (4) begin
            if (busy !== 1'b1 || !hold_match()) pre_ok = 1'b0;
            tick();
        end
        if (busy !== 1'b1 || !hold_match()) pre_ok = 1'b0;
        check("restart pre_load", {15'd0, pre_ok}, 16'd1);
        start_load(15'(7), 1'b0, 2'd0);
        wait_busy("restart");
        scan_check("restart");

        // Reset in the middle of a conversion
        start_load(15'(1234), 1'b0, 2'd0);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst busy", {15'd0, busy}, 16'h0000);
        check("midrst ssd_an", {12'd0, ssd_an}, 16'h000E);
        check("midrst ssd_in", {12'd0, ssd_in}, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cur_disp = 16'hEEE0;
        exp_q.push_back(16'hEEE0);
        scan_check("midrst");
        repeat (20) tick();
        check("midrst busy_after", {15'd0, busy}, 16'h0000);
        exp_q.push_back(16'hEEE0);
        scan_check("midrst_stable");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
